// File: rtl/and_match_pkg.sv
// rtl/and_match_pkg.sv - shared state encoding and threshold constants for and_match_detector
package and_match_pkg;

  // Detector FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COUNT   = 2'd1;
  localparam logic [1:0] ST_MATCHED = 2'd2;

  // A programmed THRESH of zero behaves as a threshold of one hit
  localparam int THRESH_ZERO_EFF = 1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and async active-low reset
module sat_counter #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  // Clear wins over increment; the count holds once it reaches all-ones
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Q <= '0;
    end else if (CLR) begin
      Q <= '0;
    end else if (INC && (Q != {W{1'b1}})) begin
      Q <= Q + W'(1);
    end
  end

endmodule

// File: rtl/and_match_detector.sv
// rtl/and_match_detector.sv - debounced pattern detector on masked AND-gate output; option macro AND_MATCH_STICKY_EN
module and_match_detector
  import and_match_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [CNT_W-1:0] THRESH,
  output logic             MATCH,
  output logic             MATCH_PULSE,
  output logic [CNT_W-1:0] CNT
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             hit;
  logic             flush;
  logic             cnt_clr;
  logic             pulse_d;
  logic             pulse_q;
  logic [CNT_W-1:0] thr_eff;
  logic [CNT_W-1:0] cnt_inc;

  assign hit     = EN & (IN0 == PATTERN);
  assign flush   = CLR | ~EN;
  assign thr_eff = (THRESH == '0) ? CNT_W'(THRESH_ZERO_EFF) : THRESH;
  // Value CNT will take after this edge's hit, used to decide entry to MATCHED in the same edge
  assign cnt_inc = (CNT == {CNT_W{1'b1}}) ? CNT : CNT + CNT_W'(1);
  // Any non-hit (including disable) restarts the run; CLR overrides a simultaneous hit
  assign cnt_clr = flush | ~hit;

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .CLK  (CLK),
    .RSTn (RSTn),
    .CLR  (cnt_clr),
    .INC  (hit),
    .Q    (CNT)
  );

  // State and pulse registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= ST_IDLE;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pulse_q <= pulse_d;
    end
  end

  // Next-state selection: clear/disable first, then the hit-run FSM
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state_nxt = (thr_eff == CNT_W'(1)) ? ST_MATCHED : ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!hit) begin
            state_nxt = ST_IDLE;
          end else if (cnt_inc >= thr_eff) begin
            // >= lets a lowered THRESH complete the run on the next hit
            state_nxt = ST_MATCHED;
          end
        end
        ST_MATCHED: begin
          if (!hit) begin
`ifdef AND_MATCH_STICKY_EN
            state_nxt = ST_MATCHED;
`else
            state_nxt = ST_IDLE;
`endif
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs: level follows the state register, pulse marks only the entering edge
  always_comb begin
    MATCH       = (state == ST_MATCHED);
    pulse_d     = (state_nxt == ST_MATCHED) && (state != ST_MATCHED);
    MATCH_PULSE = pulse_q;
  end

endmodule

// File: tb/tb_and_match_detector.sv
// tb/tb_and_match_detector.sv - scoreboard bench for and_match_detector with a run-length reference model
module tb_and_match_detector;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK;
  logic             RSTn;
  logic             EN;
  logic             CLR;
  logic [WIDTH-1:0] IN0;
  logic [WIDTH-1:0] PATTERN;
  logic [CNT_W-1:0] THRESH;
  logic             MATCH;
  logic             MATCH_PULSE;
  logic [CNT_W-1:0] CNT;

  and_match_detector #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .EN          (EN),
    .CLR         (CLR),
    .IN0         (IN0),
    .PATTERN     (PATTERN),
    .THRESH      (THRESH),
    .MATCH       (MATCH),
    .MATCH_PULSE (MATCH_PULSE),
    .CNT         (CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit m;
    bit p;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 0;

  // Reference model: length of the current hit run and whether a match has been declared
  int  run     = 0;
  bit  matched = 0;
  bit  pulse   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic model_step(input bit rstn, input bit en, input bit clr,
                            input logic [WIDTH-1:0] in0, input logic [WIDTH-1:0] pat,
                            input int thr);
    int  teff;
    bit  was;
    teff = (thr == 0) ? 1 : thr;
    if (!rstn || clr || !en) begin
      run = 0; matched = 0; pulse = 0;
    end else if (in0 == pat) begin
      was = matched;
      run = (run + 1 > CMAX) ? CMAX : run + 1;
      if (run >= teff) matched = 1;
      pulse = matched && !was;
    end else begin
      run = 0;
      pulse = 0;
`ifndef AND_MATCH_STICKY_EN
      matched = 0;
`endif
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the response expected after the next rising edge
  task automatic step(input bit rstn, input bit en, input bit clr,
                      input logic [WIDTH-1:0] in0, input logic [WIDTH-1:0] pat, input int thr);
    exp_t e;
    @(negedge CLK);
    RSTn = rstn; EN = en; CLR = clr; IN0 = in0; PATTERN = pat; THRESH = CNT_W'(thr);
    model_step(rstn, en, clr, in0, pat, thr);
    e.m = matched; e.p = pulse; e.c = run;
    exp_q.push_back(e);
  endtask

  task automatic hit_run(input int n, input int thr);
    for (int i = 0; i < n; i++) step(1, 1, 0, 4'hA, 4'hA, thr);
  endtask

  // Monitor: compare DUT outputs just after each rising edge against the oldest queued expectation
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("match", int'(MATCH), int'(e.m));
        check("pulse", int'(MATCH_PULSE), int'(e.p));
        check("cnt", int'(CNT), e.c);
      end
    end
  end

  initial begin
    int wait_cnt;
    logic [WIDTH-1:0] pat_r;
    logic [WIDTH-1:0] in_r;
    RSTn = 0; EN = 0; CLR = 0; IN0 = '0; PATTERN = '0; THRESH = '0;
    #2;
    check("reset_match", int'(MATCH), 0);
    check("reset_pulse", int'(MATCH_PULSE), 0);
    check("reset_cnt", int'(CNT), 0);
    step(0, 0, 0, 0, 0, 0);

    // Basic three-hit match, then a miss
    hit_run(3, 3);
    step(1, 1, 0, 4'h5, 4'hA, 3);
    step(1, 1, 0, 4'h5, 4'hA, 3);
    // Broken run
    step(1, 1, 1, 0, 4'hA, 3);
    step(1, 1, 0, 4'hA, 4'hA, 3);
    step(1, 1, 0, 4'hA, 4'hA, 3);
    step(1, 1, 0, 4'h5, 4'hA, 3);
    hit_run(3, 3);
    // THRESH of zero
    step(1, 1, 1, 0, 4'hA, 0);
    hit_run(1, 0);
    // Saturation with THRESH=1
    step(1, 1, 1, 0, 4'hA, 1);
    hit_run(10, 1);
    // CLR and EN=0 override a hit while matched
    step(1, 1, 1, 4'hA, 4'hA, 1);
    hit_run(2, 1);
    step(1, 0, 0, 4'hA, 4'hA, 1);
    // THRESH lowered mid-count
    hit_run(3, 6);
    hit_run(1, 2);
    hit_run(1, 2);
    // Async reset mid-count, between edges
    step(1, 1, 1, 0, 4'hA, 5);
    hit_run(2, 5);
    @(negedge CLK);
    #2;
    RSTn = 0;
    #1;
    check("async_match", int'(MATCH), 0);
    check("async_pulse", int'(MATCH_PULSE), 0);
    check("async_cnt", int'(CNT), 0);
    model_step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 4'hA, 4'hA, 5);
    // Non-hit in MATCHED, followed by another hit
    hit_run(2, 2);
    step(1, 1, 0, 4'h3, 4'hA, 2);
    step(1, 1, 0, 4'h3, 4'hA, 2);
    hit_run(2, 2);

    // Randomized traffic
    pat_r = 4'hA;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) pat_r = WIDTH'($urandom);
      in_r = ($urandom_range(0, 3) != 0) ? pat_r : WIDTH'($urandom);
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 29) == 0), in_r, pat_r, int'($urandom_range(0, CMAX)));
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge CLK);
      wait_cnt++;
    end
    check("queue_drained", exp_q.size(), 0);
    done = 1;
    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
